if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//   Parametrised IF/ID pipeline buffer: a DEPTH-entry FIFO of {pc, inst} pairs between
//   the fetch and decode stages. Replaces the single IF/ID register with valid/ready
//   handshakes on both sides, so decode can stall without dropping fetched
//   instructions. Also provides a flush input that squashes all buffered entries on a
//   branch or exception redirect.
// PARAMETERS
//   ADDR_W  32  width of the instruction address (pc)
//   INST_W  32  width of the instruction word
//   DEPTH   4   number of entries; must be a power of 2 and >= 2
//   CNT_W   $clog2(DEPTH)+1  width of the occupancy count (derived, not overridden)
// PORTS
//   clk        in   1       clock; all state updates on the rising edge
//   rst        in   1       reset, synchronous, active-high
//   flush      in   1       discard all entries (pipeline redirect)
//   if_valid   in   1       fetch presents a valid {if_pc, if_inst}
//   if_ready   out  1       buffer can accept an entry this cycle
//   if_pc      in   ADDR_W  pc of the fetched instruction
//   if_inst    in   INST_W  fetched instruction word
//   id_valid   out  1       head entry is valid for decode
//   id_ready   in   1       decode consumes the head entry this cycle
//   id_pc      out  ADDR_W  pc of the head entry
//   id_inst    out  INST_W  instruction word of the head entry
//   count      out  CNT_W   current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0. Outputs then read
//     id_valid=0, id_pc=0, id_inst=0, if_ready=1. Storage contents are don't-care.
//   - push = if_valid & if_ready; pop = id_valid & id_ready.
//   - if_ready = (count != DEPTH). It depends only on registered state, with no
//     combinational path from id_ready. When full, a same-cycle pop does NOT allow a push.
//   - id_valid = (count != 0).
//   - id_pc/id_inst = head entry when id_valid=1. When empty, both are forced to zero
//     (bubble = nop).
//   - Latency: an entry pushed at edge N is visible on id_* after edge N. There is no
//     same-cycle bypass from if_* to id_*.
//   - Order is strict FIFO.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Simultaneous push and pop: both pointers advance and count is unchanged. This is
//     legal at any occupancy 1..DEPTH-1.
//   - Pop with count=0 is impossible by construction (id_valid=0).
//   - Push with count=DEPTH is impossible by construction (if_ready=0).
//   - Stall: while id_ready=0, id_valid/id_pc/id_inst hold stable. Fetch continues until
//     the buffer is full.
//   - flush=1 at an edge: count=0, wr_ptr=rd_ptr=0. Any same-cycle push and pop are
//     discarded. From the next cycle: id_valid=0, id_* =0, if_ready=1.
//   - Priority: rst > flush > push/pop.
//   - if_valid/if_pc/if_inst are don't-care while if_ready=0.
// TESTING
//   1. Reset: rst=1 for 2 cycles with if_valid=1 -> count=0, id_valid=0,
//      id_pc=id_inst=0, if_ready=1.
//   2. Single pass: push pc=0x100, inst=0x24010005 with id_ready=1 -> id_valid=1 with
//      those values exactly 1 cycle later; count returns to 0 the next cycle.
//   3. Fill/stall: id_ready=0, push pcs 0x0,0x4,0x8,0xC (DEPTH=4) -> count=4,
//      if_ready=0, id_pc held at 0x0. Release id_ready -> pcs 0x0..0xC appear in order,
//      one per cycle.
//   4. Streaming wrap: continuous push/pop for 10 cycles at count=2 -> count stays 2,
//      pcs emerge in order across pointer wrap, no loss or duplication.
//   5. Flush: count=3, assert flush together with if_valid=1 and id_ready=1 -> next
//      cycle count=0, id_valid=0, id_* =0. The flushed push never appears.
//   6. Full-with-pop: count=4, id_ready=1, if_valid=1 -> pop only, count=3, and the
//      offered entry is accepted on the following cycle.

Source files
------------

// File: rtl/if_id_queue.sv
// IF/ID pipeline buffer: DEPTH-entry FIFO of {pc, inst} pairs with flush.
// Ports: clk, rst, flush, if_valid/if_ready/if_pc/if_inst, id_valid/id_ready/id_pc/id_inst, count.
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   // Ready comes only from registered occupancy, so a pop while full
   // does not open a slot in the same cycle.
   assign if_ready = (count != CNT_W'(DEPTH));
   assign id_valid = (count != '0);
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & id_ready;

   // Empty buffer presents a zero bubble to decode.
   assign id_pc   = id_valid ? pc_mem[rd_ptr]   : '0;
   assign id_inst = id_valid ? inst_mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         pc_mem[wr_ptr]   <= if_pc;
         inst_mem[wr_ptr] <= if_inst;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_if_id_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   logic [63:0] q[$];

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_inst(if_inst),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_inst(id_inst),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference model: FIFO semantics from the rules, updated at each edge.
   always @(posedge clk) begin
      bit do_push, do_pop;
      do_push = if_valid && (q.size() != DEPTH);
      do_pop  = id_ready && (q.size() != 0);
      if (rst || flush) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({if_pc, if_inst});
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("m_count", 64'(count), 64'(q.size()));
         chk("m_if_ready", 64'(if_ready), 64'(q.size() != DEPTH));
         chk("m_id_valid", 64'(id_valid), 64'(q.size() != 0));
         chk("m_id_pc", 64'(id_pc), q.size() != 0 ? 64'(q[0][63:32]) : 64'd0);
         chk("m_id_inst", 64'(id_inst), q.size() != 0 ? 64'(q[0][31:0]) : 64'd0);
      end
   end

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   // Drive inputs on the falling edge, then wait across one rising edge.
   task automatic step(input logic v, input logic [31:0] pc,
                       input logic rdy, input logic fl);
      if_valid = v;
      if_pc    = pc;
      if_inst  = mk_inst(pc);
      id_ready = rdy;
      flush    = fl;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; if_valid = 1'b1;
      if_pc = 32'h50; if_inst = 32'h1; id_ready = 1'b0;
      @(negedge clk);
      step(1'b1, 32'h50, 1'b0, 1'b0);
      step(1'b1, 32'h54, 1'b0, 1'b0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_id_valid", 64'(id_valid), 64'd0);
      chk("rst_id_pc", 64'(id_pc), 64'd0);
      chk("rst_id_inst", 64'(id_inst), 64'd0);
      chk("rst_if_ready", 64'(if_ready), 64'd1);
      rst = 1'b0;
      check_en = 1'b1;

      // single pass
      if_inst = 32'h24010005;
      if_valid = 1'b1; if_pc = 32'h100; id_ready = 1'b1; flush = 1'b0;
      @(negedge clk);
      chk("sp_id_valid", 64'(id_valid), 64'd1);
      chk("sp_id_pc", 64'(id_pc), 64'h100);
      chk("sp_id_inst", 64'(id_inst), 64'h24010005);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("sp_count0", 64'(count), 64'd0);

      // fill and stall
      for (int i = 0; i < 4; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b0);
      chk("fill_count", 64'(count), 64'd4);
      chk("fill_if_ready", 64'(if_ready), 64'd0);
      chk("fill_id_pc", 64'(id_pc), 64'h0);
      step(1'b1, 32'h10, 1'b0, 1'b0);
      chk("stall_id_pc", 64'(id_pc), 64'h0);
      chk("stall_count", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", 64'(id_pc), 64'(4 * i));
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end
      chk("drain_empty", 64'(count), 64'd0);

      // streaming across pointer wrap
      step(1'b1, 32'h200, 1'b0, 1'b0);
      step(1'b1, 32'h204, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 32'(32'h208 + 4 * k), 1'b1, 1'b0);
         chk("stream_count", 64'(count), 64'd2);
         chk("stream_pc", 64'(id_pc), 64'(32'h200 + 4 * (k + 1)));
      end
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // flush with concurrent push and pop
      for (int i = 0; i < 3; i++) step(1'b1, 32'(32'h500 + 4 * i), 1'b0, 1'b0);
      chk("pre_flush_count", 64'(count), 64'd3);
      step(1'b1, 32'h999, 1'b1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_id_valid", 64'(id_valid), 64'd0);
      chk("flush_id_pc", 64'(id_pc), 64'd0);
      chk("flush_id_inst", 64'(id_inst), 64'd0);
      chk("flush_if_ready", 64'(if_ready), 64'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("post_flush_count", 64'(count), 64'd0);

      // full with pop: pop only, push lands next cycle
      for (int i = 0; i < 4; i++) step(1'b1, 32'(32'h300 + 4 * i), 1'b0, 1'b0);
      step(1'b1, 32'h400, 1'b1, 1'b0);
      chk("fwp_count", 64'(count), 64'd3);
      chk("fwp_id_pc", 64'(id_pc), 64'h304);
      step(1'b1, 32'h400, 1'b0, 1'b0);
      chk("fwp_count4", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk("fwp_order", 64'(id_pc), i < 3 ? 64'(32'h308 + 4 * i - 4) : 64'h400);
         step(1'b0, 32'h0, 1'b1, 1'b0);
      end

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 99) < 60, $urandom(), $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) == 0);
      end
      rst = 1'b0;
      step(1'b0, 32'h0, 1'b0, 1'b0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
